// File: rtl/psum_writeback_if.sv
// rtl/psum_writeback_if.sv - OFIFO head and psum SRAM port bundle for psum_writeback
interface psum_writeback_if #(
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int addr_bw = 11
) ();
   logic                   ofifo_valid;
   logic [psum_bw*col-1:0] psum_in;
   logic                   ofifo_rd;
   logic                   sram_cen;
   logic                   sram_wen;
   logic [addr_bw-1:0]     sram_addr;
   logic [psum_bw*col-1:0] sram_wdata;
   logic [psum_bw*col-1:0] sram_rdata;

   modport master (
      input  ofifo_valid,
      input  psum_in,
      input  sram_rdata,
      output ofifo_rd,
      output sram_cen,
      output sram_wen,
      output sram_addr,
      output sram_wdata
   );

   modport slave (
      output ofifo_valid,
      output psum_in,
      output sram_rdata,
      input  ofifo_rd,
      input  sram_cen,
      input  sram_wen,
      input  sram_addr,
      input  sram_wdata
   );
endinterface

// File: rtl/psum_writeback.sv
// rtl/psum_writeback.sv - drains OFIFO psum vectors into SRAM with optional accumulate/ReLU; PSUM_WRITEBACK_SAT_EN selects saturating sums
module psum_writeback #(
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int addr_bw = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [addr_bw-1:0] base_addr,
   input  logic [addr_bw-1:0] length,
   input  logic               acc_en,
   input  logic               relu_en,
   output logic               busy,
   output logic               done,
   psum_writeback_if.master   bus
);
   localparam int                 vec_bw   = psum_bw * col;
   localparam logic [addr_bw-1:0] addr_one = addr_bw'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nx;

   // job parameters captured when start is accepted
   logic [addr_bw-1:0] base_q;
   logic [addr_bw-1:0] length_q;
   logic               acc_q;
   logic               relu_q;

   logic [addr_bw-1:0] count;
   logic [vec_bw-1:0]  hold;
   logic [addr_bw-1:0] cur_addr;
   logic               last_vec;
   logic [vec_bw-1:0]  wb_data;

   // address wraps naturally at the addr_bw boundary
   assign cur_addr = base_q + count;
   assign last_vec = (count + addr_one) == length_q;

   // one lane: optional signed accumulate, overflow policy, then optional ReLU
   function automatic logic [psum_bw-1:0] lane_op(
      input logic [psum_bw-1:0] h,
      input logic [psum_bw-1:0] r,
      input logic               acc,
      input logic               relu
   );
      logic [psum_bw-1:0] sum;
      logic [psum_bw-1:0] s;
`ifdef PSUM_WRITEBACK_SAT_EN
      logic [psum_bw:0]   wide;
      wide = {h[psum_bw-1], h} + {r[psum_bw-1], r};
      // the two top bits disagree exactly when the sum left the lane range
      if (wide[psum_bw] != wide[psum_bw-1])
         sum = wide[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      else
         sum = wide[psum_bw-1:0];
`else
      sum = h + r;
`endif
      s = acc ? sum : h;
      if (relu && s[psum_bw-1])
         s = '0;
      return s;
   endfunction

   // write-back vector built lane by lane from the held psum and the SRAM read data
   always_comb begin
      wb_data = '0;
      for (int i = 0; i < col; i++) begin
         wb_data[i*psum_bw +: psum_bw] = lane_op(hold[i*psum_bw +: psum_bw],
                                                 bus.sram_rdata[i*psum_bw +: psum_bw],
                                                 acc_q, relu_q);
      end
   end

   // state register; reset aborts any job immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // job registers, vector counter and psum hold register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q   <= '0;
         length_q <= '0;
         acc_q    <= 1'b0;
         relu_q   <= 1'b0;
         count    <= '0;
         hold     <= '0;
      end else begin
         if (state == IDLE && start) begin
            base_q   <= base_addr;
            length_q <= length;
            acc_q    <= acc_en;
            relu_q   <= relu_en;
            count    <= '0;
         end
         if (state == WAIT && bus.ofifo_valid)
            hold <= bus.psum_in;
         if (state == WRITE)
            count <= count + addr_one;
      end
   end

   // next state and all handshake/SRAM outputs; idle values when not accessing
   always_comb begin
      state_nx       = state;
      bus.ofifo_rd   = 1'b0;
      bus.sram_cen   = 1'b1;
      bus.sram_wen   = 1'b1;
      bus.sram_addr  = '0;
      bus.sram_wdata = '0;
      busy           = (state != IDLE);
      done           = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nx = (length == '0) ? DONE : WAIT;
         end
         WAIT: begin
            if (bus.ofifo_valid) begin
               bus.ofifo_rd = 1'b1;
               if (acc_q) begin
                  bus.sram_cen  = 1'b0;
                  bus.sram_addr = cur_addr;
               end
               state_nx = WRITE;
            end
         end
         WRITE: begin
            bus.sram_cen   = 1'b0;
            bus.sram_wen   = 1'b0;
            bus.sram_addr  = cur_addr;
            bus.sram_wdata = wb_data;
            state_nx       = last_vec ? DONE : WAIT;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: doc/psum_writeback.md
PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 SHALL have parameter psum_bw, default 16, width of one partial-sum lane.
REQ-002 SHALL have parameter col, default 8, number of lanes per vector.
REQ-003 SHALL have parameter addr_bw, default 11, psum SRAM address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins a drain job.
REQ-007 SHALL have port base_addr  input  addr_bw  first SRAM address of the job, sampled on start.
REQ-008 SHALL have port length  input  addr_bw  vectors to drain, sampled on start.
REQ-009 SHALL have port acc_en  input  1  accumulate into SRAM contents, sampled on start.
REQ-010 SHALL have port relu_en  input  1  apply ReLU before write, sampled on start.
REQ-011 SHALL have port ofifo_valid  input  1  output FIFO holds at least one vector.
REQ-012 SHALL have port psum_in  input  psum_bw*col  head OFIFO vector (first-word fall-through), lane i at bits [psum_bw*(i+1)-1:psum_bw*i].
REQ-013 SHALL have port ofifo_rd  output  1  pops the OFIFO head on the rising edge where it is high.
REQ-014 SHALL have port sram_cen  output  1  SRAM chip enable, active-low.
REQ-015 SHALL have port sram_wen  output  1  SRAM write enable, active-low.
REQ-016 SHALL have port sram_addr  output  addr_bw  SRAM address.
REQ-017 SHALL have port sram_wdata  output  psum_bw*col  SRAM write data.
REQ-018 SHALL have port sram_rdata  input  psum_bw*col  SRAM read data, valid one cycle after a read.
REQ-019 SHALL have port busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-020 SHALL have port done  output  1  one-cycle pulse at job completion.

Function
REQ-021 SHALL implement FSM IDLE, WAIT, WRITE, DONE.
REQ-022 IDLE: on start SHALL latch base_addr, length, acc_en, relu_en, clear count; go to DONE if length==0, else WAIT.
REQ-023 WAIT: while ofifo_valid==0 SHALL drive ofifo_rd=0, sram_cen=1 and stay.
REQ-024 WAIT with ofifo_valid==1: SHALL assert ofifo_rd=1 combinationally, capture psum_in into a hold register, and, if acc_en, issue read (cen=0, wen=1, addr=base+count); next state WRITE.
REQ-025 WRITE: SHALL drive cen=0, wen=0, addr=base+count, wdata=f(hold, sram_rdata); increment count; go to DONE if count+1==length, else WAIT.
REQ-026 Per lane, f SHALL be: s = acc_en ? hold+rdata (signed two's complement, psum_bw bits) : hold; then relu_en and s<0 gives 0, else s.
REQ-027 Address SHALL be base_addr+count modulo 2^addr_bw (wraps past max address).
REQ-028 DONE: done=1 for exactly one cycle, then IDLE.
REQ-029 Throughput SHALL be one vector per two cycles when ofifo_valid is continuously high.
REQ-030 start SHALL be ignored unless in IDLE; a start in the DONE cycle is dropped.
REQ-031 ofifo_rd SHALL never be high when ofifo_valid is low or outside WAIT.
REQ-032 Outside WAIT-with-read and WRITE, sram_cen and sram_wen SHALL be 1.

Reset
REQ-033 On reset low, FSM SHALL go to IDLE immediately, regardless of clock, including mid-job.
REQ-034 Reset values: ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_wdata=0, busy=0, done=0, count and hold registers 0.
REQ-035 An aborted job SHALL not resume after reset release; no done pulse is produced.

Configuration
REQ-036 Macro PSUM_WRITEBACK_SAT_EN SHALL select accumulation overflow handling.
REQ-037 With PSUM_WRITEBACK_SAT_EN defined, lane sums SHALL saturate to +2^(psum_bw-1)-1 or -2^(psum_bw-1).
REQ-038 Without it, lane sums SHALL wrap modulo 2^psum_bw.

Verification
REQ-039 Bench SHALL cover: acc_en=0, relu_en=0, base=0x10, length=3, FIFO preloaded -> writes to 0x10,0x11,0x12 on cycles 2,4,6 after start; done 1 cycle after last write.
REQ-040 Bench SHALL cover: acc_en=1, SRAM lane=100, psum lane=-150, relu_en=1 -> written lane 0; relu_en=0 -> -50.
REQ-041 Bench SHALL cover: acc_en=1, lane 32767+1 -> 32767 with SAT_EN, -32768 without.
REQ-042 Bench SHALL cover: base=0x7FF, length=2 -> addresses 0x7FF then 0x000; ofifo_valid toggled low 3 cycles -> FSM holds WAIT, ofifo_rd=0.
REQ-043 Bench SHALL cover: length=0 -> done one cycle after start, no SRAM access, no pop; start while busy -> ignored.
REQ-044 Bench SHALL cover: reset asserted in WRITE -> outputs at reset values same cycle, IDLE after release, no done.
